// File: rtl/axis_exp_adc_emu.sv
// Target-side emulator of the four-lane SPI ADC: oversampled SPI inputs, conversion
// busy timing, register-access command decode and 1/2/4-lane sample readout.
//
// state   | meaning
// IDLE    | no unread sample, waiting for cnv
// CONVERT | busy high, counting down the conversion time
// READY   | sample latched, waiting for a csn fall to read it
// SHIFT   | read in progress, one group per sck rise
module axis_exp_adc_emu #(
   parameter int DATA_WIDTH = 32,
   parameter int CNV_CYCLES = 14,
   parameter int CMD_WIDTH  = 24
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  spi_sck,
   input  logic                  spi_csn,
   input  logic                  spi_sdi,
   input  logic                  spi_cnv,
   input  logic                  spi_resetn,
   output logic                  spi_busy,
   output logic [3:0]            spi_sdo,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [CMD_WIDTH-1:0]  cmd_data,
   output logic                  cmd_valid,
   output logic                  reg_mode,
   output logic [1:0]            lane_mode,
   output logic                  underrun
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CONVERT = 2'd1;
   localparam logic [1:0] ST_READY   = 2'd2;
   localparam logic [1:0] ST_SHIFT   = 2'd3;

   localparam int CNT_W = $clog2(CNV_CYCLES + 1);
   localparam int CCW   = $clog2(CMD_WIDTH + 1);
   localparam int GW    = $clog2(DATA_WIDTH);

   function automatic logic [3:0] top_group(input logic [DATA_WIDTH-1:0] v, input logic [1:0] m);
      case (m)
         2'b10:   top_group = v[DATA_WIDTH-1 -: 4];
         2'b01:   top_group = {2'b00, v[DATA_WIDTH-1 -: 2]};
         default: top_group = {3'b000, v[DATA_WIDTH-1]};
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] drop_group(input logic [DATA_WIDTH-1:0] v, input logic [1:0] m);
      case (m)
         2'b10:   drop_group = v << 4;
         2'b01:   drop_group = v << 2;
         default: drop_group = v << 1;
      endcase
   endfunction

   function automatic logic [GW-1:0] last_group(input logic [1:0] m);
      case (m)
         2'b10:   last_group = GW'(DATA_WIDTH / 4 - 1);
         2'b01:   last_group = GW'(DATA_WIDTH / 2 - 1);
         default: last_group = GW'(DATA_WIDTH - 1);
      endcase
   endfunction

   // bit order in the synchronizer: {resetn, cnv, sdi, csn, sck}
   logic [4:0] sync_a, sync_b;
   logic [2:0] prev;

   always_ff @(posedge aclk) begin
      if (areset) begin
         sync_a <= 5'b10010;
         sync_b <= 5'b10010;
         prev   <= 3'b010;
      end else begin
         sync_a <= {spi_resetn, spi_cnv, spi_sdi, spi_csn, spi_sck};
         sync_b <= sync_a;
         prev   <= {sync_b[3], sync_b[1], sync_b[0]};
      end
   end

   logic sck_rise, csn_fall, csn_rise, csn_low, sdi_s, cnv_rise, dev_rst;
   assign sck_rise = sync_b[0] & ~prev[0];
   assign csn_fall = ~sync_b[1] & prev[1];
   assign csn_rise = sync_b[1] & ~prev[1];
   assign csn_low  = ~sync_b[1];
   assign sdi_s    = sync_b[2];
   assign cnv_rise = sync_b[3] & ~prev[2];
   assign dev_rst  = areset | ~sync_b[4];

   logic [CMD_WIDTH-1:0] cmd_sh;
   logic [CCW-1:0]       cmd_cnt;

   always_ff @(posedge aclk) begin
      if (dev_rst) begin
         cmd_sh  <= '0;
         cmd_cnt <= '0;
      end else if (csn_fall) begin
         cmd_sh  <= '0;
         cmd_cnt <= '0;
      end else if (sck_rise && csn_low) begin
         cmd_sh <= {cmd_sh[CMD_WIDTH-2:0], sdi_s};
         if (cmd_cnt != CCW'(CMD_WIDTH)) cmd_cnt <= cmd_cnt + 1'b1;
      end
   end

   logic       cmd_done, reg_mode_nxt;
   logic [1:0] lane_mode_nxt;

   always_comb begin
      cmd_done      = csn_rise && (cmd_cnt == CCW'(CMD_WIDTH));
      reg_mode_nxt  = reg_mode;
      lane_mode_nxt = lane_mode;
      if (cmd_done) begin
         if (cmd_sh[CMD_WIDTH-1 -: 3] == 3'b101) begin
            reg_mode_nxt = 1'b1;
         end else if (reg_mode && cmd_sh[CMD_WIDTH-1 -: 16] == 16'h8020) begin
            if (cmd_sh[7:6] != 2'b11) lane_mode_nxt = cmd_sh[7:6];
         end else if (reg_mode && cmd_sh[CMD_WIDTH-1 -: 16] == 16'h8014 && cmd_sh[0]) begin
            reg_mode_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (dev_rst) begin
         cmd_data  <= '0;
         cmd_valid <= 1'b0;
         reg_mode  <= 1'b0;
         lane_mode <= 2'b00;
      end else begin
         cmd_valid <= cmd_done;
         if (cmd_done) cmd_data <= cmd_sh;
         reg_mode  <= reg_mode_nxt;
         lane_mode <= lane_mode_nxt;
      end
   end

   logic [1:0]            state;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] sample, work;
   logic [GW-1:0]         grp_left;
   logic [1:0]            xfer_mode;
   logic                  data_ready;

   always_ff @(posedge aclk) begin
      if (dev_rst) begin
         state         <= ST_IDLE;
         spi_busy      <= 1'b0;
         spi_sdo       <= 4'h0;
         s_axis_tready <= 1'b0;
         data_ready    <= 1'b0;
         cnt           <= '0;
         sample        <= '0;
         work          <= '0;
         grp_left      <= '0;
         xfer_mode     <= 2'b00;
         if (areset) underrun <= 1'b0;
      end else begin
         s_axis_tready <= 1'b0;
         case (state)
            ST_IDLE, ST_READY: begin
               // reg_mode_nxt lets a same-cycle exit command enable this conversion
               if (cnv_rise && !reg_mode_nxt) begin
                  state    <= ST_CONVERT;
                  spi_busy <= 1'b1;
                  cnt      <= CNT_W'(CNV_CYCLES);
               end else if (state == ST_READY && csn_fall && data_ready && !reg_mode) begin
                  state      <= ST_SHIFT;
                  xfer_mode  <= lane_mode;
                  spi_sdo    <= top_group(sample, lane_mode);
                  work       <= drop_group(sample, lane_mode);
                  grp_left   <= last_group(lane_mode);
                  data_ready <= (last_group(lane_mode) != '0);
               end
            end
            ST_CONVERT: begin
               if (cnt == CNT_W'(1)) begin
                  spi_busy   <= 1'b0;
                  data_ready <= 1'b1;
                  state      <= ST_READY;
                  if (s_axis_tvalid) begin
                     sample        <= s_axis_tdata;
                     s_axis_tready <= 1'b1;
                  end else begin
                     underrun <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_SHIFT: begin
               if (csn_rise) begin
                  spi_sdo <= 4'h0;
                  state   <= data_ready ? ST_READY : ST_IDLE;
               end else if (sck_rise) begin
                  if (grp_left != '0) begin
                     spi_sdo  <= top_group(work, xfer_mode);
                     work     <= drop_group(work, xfer_mode);
                     grp_left <= grp_left - 1'b1;
                     if (grp_left == GW'(1)) data_ready <= 1'b0;
                  end else begin
                     spi_sdo <= 4'h0;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_exp_adc_emu.sv
// Bench for axis_exp_adc_emu: drives the SPI initiator side and AXI-Stream source,
// predicts readout groups, command results and busy timing from a behavioural model.
module tb_axis_exp_adc_emu;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        spi_sck = 1'b0, spi_csn = 1'b1, spi_sdi = 1'b0, spi_cnv = 1'b0, spi_resetn = 1'b1;
   logic        spi_busy;
   logic [3:0]  spi_sdo;
   logic [31:0] s_axis_tdata = 32'h0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [23:0] cmd_data;
   logic        cmd_valid;
   logic        reg_mode;
   logic [1:0]  lane_mode;
   logic        underrun;

   always #5 aclk = ~aclk;

   axis_exp_adc_emu #(.DATA_WIDTH(32), .CNV_CYCLES(14), .CMD_WIDTH(24)) dut (
      .aclk(aclk), .areset(areset),
      .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_sdi(spi_sdi), .spi_cnv(spi_cnv),
      .spi_resetn(spi_resetn), .spi_busy(spi_busy), .spi_sdo(spi_sdo),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .reg_mode(reg_mode),
      .lane_mode(lane_mode), .underrun(underrun)
   );

   int n_chk = 0, n_fail = 0;
   int busy_n = 0, tready_n = 0, cv_n = 0, zero_viol = 0;
   bit zero_en = 1'b0;

   // behavioural model of the emulator's visible state
   logic [31:0] m_sample = 32'h0;
   logic [23:0] m_cmd = 24'h0;
   logic [1:0]  m_lane = 2'b00;
   bit          m_underrun = 1'b0, m_ready = 1'b0, m_reg = 1'b0;
   int          m_cv = 0;

   // per-cycle monitor: busy/tready/cmd_valid accounting and sdo quiet during command frames
   always @(negedge aclk) begin
      if (spi_busy === 1'b1) busy_n++;
      if (s_axis_tready === 1'b1) tready_n++;
      if (cmd_valid === 1'b1) cv_n++;
      if (zero_en && spi_sdo !== 4'h0) zero_viol++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge aclk);
   endtask

   function automatic logic [3:0] grp(input logic [31:0] s, input int g, input int j);
      logic [31:0] t;
      t = s >> (32 - (j + 1) * g);
      return 4'(t & ((32'd1 << g) - 32'd1));
   endfunction

   function automatic int lane_bits(input logic [1:0] m);
      return (m == 2'b10) ? 4 : (m == 2'b01) ? 2 : 1;
   endfunction

   task automatic send_cmd(input logic [23:0] c, input int nbits);
      int z0;
      z0 = zero_viol;
      zero_en = 1'b1;
      spi_csn = 1'b0; tick(5);
      for (int i = 0; i < nbits; i++) begin
         spi_sdi = c[23-i]; tick(3);
         spi_sck = 1'b1; tick(5);
         spi_sck = 1'b0; tick(2);
      end
      spi_sdi = 1'b0;
      spi_csn = 1'b1; tick(6);
      zero_en = 1'b0;
      if (nbits == 24) begin
         m_cmd = c;
         m_cv++;
         if (c[23:21] == 3'b101) m_reg = 1'b1;
         else if (m_reg && c[23:8] == 16'h8020) begin
            if (c[7:6] != 2'b11) m_lane = c[7:6];
         end else if (m_reg && c[23:8] == 16'h8014 && c[0]) m_reg = 1'b0;
      end
      chk("cmd_frame_sdo_quiet", 32'(zero_viol - z0), 32'd0);
      chk("cmd_data", 32'(cmd_data), 32'(m_cmd));
      chk("cmd_valid_count", 32'(cv_n), 32'(m_cv));
      chk("reg_mode", 32'(reg_mode), 32'(m_reg));
      chk("lane_mode", 32'(lane_mode), 32'(m_lane));
   endtask

   task automatic convert(input bit valid, input logic [31:0] data);
      int b0, t0;
      bit run;
      b0 = busy_n; t0 = tready_n; run = !m_reg;
      s_axis_tdata = data; s_axis_tvalid = valid;
      spi_cnv = 1'b1; tick(25);
      spi_cnv = 1'b0; s_axis_tvalid = 1'b0; tick(3);
      if (run) begin
         if (valid) m_sample = data;
         else m_underrun = 1'b1;
         m_ready = 1'b1;
      end
      chk("busy_cycles", 32'(busy_n - b0), run ? 32'd14 : 32'd0);
      chk("tready_pulses", 32'(tready_n - t0), (run && valid) ? 32'd1 : 32'd0);
      chk("underrun", 32'(underrun), 32'(m_underrun));
      chk("busy_low_after", 32'(spi_busy), 32'd0);
   endtask

   task automatic do_read(input int nsck, output logic [31:0] word);
      int g, n;
      bit active;
      logic [3:0] e;
      g = lane_bits(m_lane); n = 32 / g;
      active = m_ready && !m_reg;
      word = 32'h0;
      spi_csn = 1'b0; tick(5);
      e = active ? grp(m_sample, g, 0) : 4'h0;
      chk("sdo_group0", 32'(spi_sdo), 32'(e));
      if (active) word = (word << g) | 32'(spi_sdo);
      for (int j = 1; j <= nsck; j++) begin
         spi_sck = 1'b1; tick(5);
         e = (active && j < n) ? grp(m_sample, g, j) : 4'h0;
         chk($sformatf("sdo_sck%0d", j), 32'(spi_sdo), 32'(e));
         if (active && j < n) word = (word << g) | 32'(spi_sdo);
         spi_sck = 1'b0; tick(5);
      end
      spi_csn = 1'b1; tick(6);
      if (active && nsck >= n - 1) m_ready = 1'b0;
      if (nsck >= 24) begin
         m_cmd = 24'h0;
         m_cv++;
      end
      chk("cmd_valid_count_read", 32'(cv_n), 32'(m_cv));
      chk("sdo_idle_after_read", 32'(spi_sdo), 32'd0);
   endtask

   initial begin
      logic [31:0] w, es, r;
      logic [1:0]  lm;
      bit          act, skip_exit;
      int          n;

      tick(5);
      areset = 1'b0;
      tick(5);
      chk("rst_busy", 32'(spi_busy), 32'd0);
      chk("rst_sdo", 32'(spi_sdo), 32'd0);
      chk("rst_tready", 32'(s_axis_tready), 32'd0);
      chk("rst_cmd_data", 32'(cmd_data), 32'd0);
      chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      chk("rst_reg_mode", 32'(reg_mode), 32'd0);
      chk("rst_lane_mode", 32'(lane_mode), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);

      send_cmd(24'hA00000, 24);
      chk("enter_cmd_data", 32'(cmd_data), 32'h00A00000);
      chk("enter_reg_mode", 32'(reg_mode), 32'd1);
      convert(1'b1, 32'h12345678);
      send_cmd(24'h8020C0, 24);
      send_cmd(24'h802080, 24);
      chk("lane_four", 32'(lane_mode), 32'd2);
      send_cmd(24'h801401, 24);
      chk("exit_reg_mode", 32'(reg_mode), 32'd0);

      convert(1'b1, 32'h8BADF00D);
      do_read(8, w);
      chk("word_four_lane", w, 32'h8BADF00D);
      chk("no_underrun", 32'(underrun), 32'd0);
      do_read(3, w);

      send_cmd(24'hA00000, 24);
      send_cmd(24'h802000, 24);
      send_cmd(24'h801401, 24);
      convert(1'b0, 32'hDEADBEEF);
      chk("underrun_set", 32'(underrun), 32'd1);
      do_read(33, w);
      chk("word_one_lane_resend", w, 32'h8BADF00D);

      send_cmd(24'hA00000, 24);
      send_cmd(24'h802040, 24);
      send_cmd(24'h801401, 24);
      convert(1'b1, 32'h0023FF42);
      do_read(4, w);
      chk("partial_two_lane", w, 32'h0);
      do_read(16, w);
      chk("word_two_lane_restart", w, 32'h0023FF42);

      send_cmd(24'hA00000, 10);
      chk("short_cmd_discarded", 32'(reg_mode), 32'd0);

      for (int it = 0; it < 12; it++) begin
         lm = 2'($urandom_range(0, 3));
         send_cmd({3'b101, 21'($urandom)}, 24);
         send_cmd({16'h8020, lm, 6'($urandom)}, 24);
         skip_exit = ($urandom_range(0, 3) == 0);
         if (!skip_exit) send_cmd({16'h8014, 7'($urandom), 1'b1}, 24);
         convert($urandom_range(0, 4) != 0, $urandom);
         n = 32 / lane_bits(m_lane);
         if ($urandom_range(0, 1) == 1) do_read($urandom_range(0, n - 2), w);
         act = m_ready && !m_reg;
         es = m_sample;
         do_read(n, w);
         if (act) chk("rand_word", w, es);
      end

      send_cmd(24'hA00000, 24);
      send_cmd(24'h802080, 24);
      send_cmd(24'h801401, 24);
      r = $urandom;
      convert(1'b1, r);
      spi_csn = 1'b0; tick(5);
      repeat (2) begin
         spi_sck = 1'b1; tick(5);
         spi_sck = 1'b0; tick(5);
      end
      spi_resetn = 1'b0; tick(5);
      chk("devrst_sdo", 32'(spi_sdo), 32'd0);
      chk("devrst_lane_mode", 32'(lane_mode), 32'd0);
      chk("devrst_reg_mode", 32'(reg_mode), 32'd0);
      chk("devrst_underrun_kept", 32'(underrun), 32'(m_underrun));
      chk("devrst_cmd_data", 32'(cmd_data), 32'd0);
      spi_resetn = 1'b1; tick(5);
      spi_csn = 1'b1; tick(6);
      m_lane = 2'b00; m_reg = 1'b0; m_ready = 1'b0; m_cmd = 24'h0;
      do_read(4, w);
      convert(1'b1, 32'hCAFEF00D);
      do_read(32, w);
      chk("word_after_devrst", w, 32'hCAFEF00D);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_exp_adc_emu.md
Name: axis_exp_adc_emu

Overview:
Synthesizable emulator of the external four-lane SPI ADC, i.e. the target end of the link that axis_exp_adc drives. It oversamples spi_sck, spi_csn, spi_sdi, spi_cnv and spi_resetn on aclk and models the conversion busy time. It implements the register-access command protocol (enter, mode register, exit) and shifts AXI-Stream-supplied samples out on 1, 2 or 4 SDO lanes. It is used for loopback and hardware-in-the-loop tests without the real converter.

Parameters:
DATA_WIDTH, 32, sample width in bits; must be a multiple of 4.
CNV_CYCLES, 14, aclk cycles that spi_busy stays high after a detected cnv rise.
CMD_WIDTH, 24, register command width in bits.

Ports:
aclk  in  1  system clock; must run at least 8x spi_sck.
areset  in  1  synchronous reset, active-high.
spi_sck  in  1  SPI clock from the initiator (asynchronous).
spi_csn  in  1  chip select, active-low (asynchronous).
spi_sdi  in  1  command data from the initiator (asynchronous).
spi_cnv  in  1  conversion start; the rising edge is the event (asynchronous).
spi_resetn  in  1  device reset, active-low (asynchronous).
spi_busy  out  1  high while a conversion is in progress.
spi_sdo  out  4  sample data lanes; lane 0 is used in one-lane mode.
s_axis_tdata  in  DATA_WIDTH  next sample value.
s_axis_tvalid  in  1  sample available.
s_axis_tready  out  1  one-cycle accept pulse.
cmd_data  out  CMD_WIDTH  last complete command received.
cmd_valid  out  1  one-cycle pulse when cmd_data updates.
reg_mode  out  1  1 = register-access mode, 0 = conversion mode.
lane_mode  out  2  00 = one lane, 01 = two lanes, 10 = four lanes.
underrun  out  1  sticky; set when a conversion finds s_axis_tvalid low.

Behaviour:
- Reset is synchronous and active-high on areset. Synced spi_resetn low has the same effect as areset, except that underrun is not cleared.
- Reset values: spi_busy 0, spi_sdo 0, s_axis_tready 0, cmd_data 0, cmd_valid 0, reg_mode 0, lane_mode 00, underrun 0; FSM in IDLE; data_ready 0.
- All five SPI inputs pass through 2-flop synchronizers. Edges are detected from the synced value and its previous value.
- Edge-to-output latency is fixed at 3 aclk cycles (2 sync + 1 register) for every sdo and busy change.
- FSM states: IDLE, CONVERT, READY, SHIFT.
  - Synced cnv rise, in IDLE or READY, not in reg_mode: go to CONVERT; spi_busy=1; load counter with CNV_CYCLES.
  - A cnv rise during CONVERT is ignored. A cnv rise during SHIFT is ignored.
  - In CONVERT, when the counter reaches 0: spi_busy=0.
    - If s_axis_tvalid=1: latch s_axis_tdata into the shift register and pulse s_axis_tready for 1 cycle.
    - Otherwise: keep the previous sample and set underrun.
    - In both cases data_ready=1 and go to READY.
  - READY, csn fall, data_ready=1, not reg_mode: present the first group (MSBs) on spi_sdo and go to SHIFT. Group size is 1, 2 or 4 bits per lane_mode.
  - SHIFT, each synced sck rise: present the next lower group.
  - After the last group is presented, data_ready=0 and further sck rises drive spi_sdo=0.
  - SHIFT, csn rise: go to IDLE if the sample was fully presented. Otherwise return to READY; the next read restarts from the MSB.
- Group ordering: MSB first; lane k carries bit (group_base + k).
- Read with data_ready=0 or in reg_mode: spi_sdo stays 0 and the FSM is unchanged.
- Command shifter:
  - On csn fall: clear the shifter and the bit count.
  - On each sck rise with csn low: shift spi_sdi in at the LSB. The count saturates at CMD_WIDTH.
  - Only the last CMD_WIDTH bits are retained.
- On csn rise with count == CMD_WIDTH: update cmd_data, pulse cmd_valid, then decode (priority order):
  - bits[23:21]==101: reg_mode=1.
  - Else, if reg_mode and bits[23:8]=={1,15'h0020}: lane_mode=bits[7:6]. Value 11 is ignored.
  - Else, if reg_mode and bits[23:8]=={1,15'h0014} and bit0=1: reg_mode=0.
- A csn rise with fewer than CMD_WIDTH bits is discarded: no cmd_valid, no decode.
- A lane_mode change takes effect at the next csn fall, never mid-transfer.
- Simultaneous cnv rise and csn rise in the same cycle: the csn decode is processed first, then cnv is evaluated against the updated reg_mode.

Test Plan:
- Reset, then send 24-bit 0xA00000 -> cmd_valid pulses once, cmd_data=0xA00000, reg_mode=1; spi_sdo stays 0 during this frame.
- In reg_mode, send 0x802080, then 0x801401 -> lane_mode=10 after the first frame, reg_mode=0 after the second.
- Four lanes, s_axis sample 0x8BADF00D, cnv pulse -> busy high for 14 cycles and one tready pulse. A 32-bit read yields nibbles 8,B,A,D,F,0,0,D; underrun=0.
- One lane, s_axis_tvalid=0 at conversion end -> underrun=1 and the previous sample is re-sent. A 32-bit read returns 0x8BADF00D MSB first; the 33rd sck gives sdo=0.
- Two lanes, sample 0x0023FF42: read 4 sck, raise csn, read again -> the second read starts with 2'b00 from the MSB and the full word 0x0023FF42 is recovered.
- Assert spi_resetn low mid-SHIFT -> spi_sdo=0, IDLE, lane_mode=00, reg_mode=0; underrun keeps its prior value.
